// File: rtl/exc_ctrl_pkg.sv
// Shared CP0 definitions for the exception controller: register numbers,
// field bit positions, fixed addresses and the exception code set.
package exc_ctrl_pkg;

    localparam logic [4:0]  CP0_SR_NUM    = 5'd12;
    localparam logic [4:0]  CP0_CAUSE_NUM = 5'd13;
    localparam logic [4:0]  CP0_EPC_NUM   = 5'd14;

    localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
    localparam logic [31:0] RESET_PC         = 32'h0000_3000;

    // SR fields
    localparam int SR_IE_BIT   = 0;
    localparam int SR_EXL_BIT  = 1;
    localparam int SR_IM_LO    = 10;

    // Cause fields
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD_BIT = 31;

    localparam int NUM_HWINT = 6;

    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

endpackage

// File: rtl/exc_ctrl.sv
// CP0 subset for the 5-stage pipeline: takes interrupts/exceptions in M,
// holds SR/Cause/EPC, serves mfc0/mtc0 and exposes EPC for eret.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
    parameter logic [4:0]  SR_ADDR      = CP0_SR_NUM,
    parameter logic [4:0]  CAUSE_ADDR   = CP0_CAUSE_NUM,
    parameter logic [4:0]  EPC_ADDR     = CP0_EPC_NUM
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_valid,
    input  logic [31:0] M_PC,
    input  logic        M_BD,
    input  logic [4:0]  M_ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        M_EXLClr,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_din,
    output logic [31:0] cp0_dout,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic        EXL
);

    if (HANDLER_ADDR[1:0] != 2'b00) begin : g_bad_handler
        $error("HANDLER_ADDR must be word aligned");
    end

    // SR fields
    logic [NUM_HWINT-1:0] im_q;
    logic                 exl_q;
    logic                 ie_q;

    // Cause fields
    logic                 bd_q;
    logic [NUM_HWINT-1:0] ip_q;
    exc_code_e            exc_code_q;

    logic [31:0]          epc_q;

    logic                 int_req;
    logic                 exc_req;
    logic [31:0]          epc_target;
    logic [31:0]          sr_word;
    logic [31:0]          cause_word;

    assign int_req = M_valid & ie_q & ~exl_q & (|(HWInt & im_q));
    assign exc_req = M_valid & ~exl_q & (M_ExcCode != 5'd0);

    // Gate with reset so Req drops the instant reset asserts, even while
    // the M-stage inputs still carry an exception code.
    assign Req = reset & (int_req | exc_req);

    // A delay-slot instruction restarts at its branch.
    assign epc_target = (M_BD ? (M_PC - 32'd4) : M_PC) & ~32'd3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= EXC_INT;
            epc_q      <= '0;
        end else begin
            ip_q <= HWInt;
            if (Req) begin
                // Taking the trap wins over eret and mtc0 in the same cycle.
                exl_q      <= 1'b1;
                exc_code_q <= int_req ? EXC_INT : exc_code_e'(M_ExcCode);
                bd_q       <= M_BD;
                epc_q      <= epc_target;
            end else if (M_EXLClr) begin
                exl_q <= 1'b0;
            end else if (cp0_we) begin
                if (cp0_addr == SR_ADDR) begin
                    im_q  <= cp0_din[SR_IM_LO +: NUM_HWINT];
                    exl_q <= cp0_din[SR_EXL_BIT];
                    ie_q  <= cp0_din[SR_IE_BIT];
                end else if (cp0_addr == EPC_ADDR) begin
                    epc_q <= cp0_din & ~32'd3;
                end
            end
        end
    end

    always_comb begin
        sr_word                           = '0;
        sr_word[SR_IM_LO +: NUM_HWINT]    = im_q;
        sr_word[SR_EXL_BIT]               = exl_q;
        sr_word[SR_IE_BIT]                = ie_q;

        cause_word                        = '0;
        cause_word[CAUSE_BD_BIT]          = bd_q;
        cause_word[CAUSE_IP_LO +: NUM_HWINT] = ip_q;
        cause_word[CAUSE_EXC_LO +: 5]     = exc_code_q;
    end

    always_comb begin
        cp0_dout = '0;
        if (cp0_addr == SR_ADDR) begin
            cp0_dout = sr_word;
        end else if (cp0_addr == CAUSE_ADDR) begin
            cp0_dout = cause_word;
        end else if (cp0_addr == EPC_ADDR) begin
            cp0_dout = epc_q;
        end
    end

    assign EPCOut = epc_q;
    assign EXL    = exl_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed and randomized bench for exc_ctrl against a word-level CP0 model.
module tb_exc_ctrl;

    logic        clk;
    logic        reset;
    logic        M_valid;
    logic [31:0] M_PC;
    logic        M_BD;
    logic [4:0]  M_ExcCode;
    logic [5:0]  HWInt;
    logic        M_EXLClr;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_din;
    logic [31:0] cp0_dout;
    logic        Req;
    logic [31:0] EPCOut;
    logic        EXL;

    int checks = 0;
    int errors = 0;

    // Reference model: whole CP0 register words.
    logic [31:0] m_sr, m_cause, m_epc;

    exc_ctrl dut (
        .clk(clk), .reset(reset), .M_valid(M_valid), .M_PC(M_PC), .M_BD(M_BD),
        .M_ExcCode(M_ExcCode), .HWInt(HWInt), .M_EXLClr(M_EXLClr),
        .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_din(cp0_din),
        .cp0_dout(cp0_dout), .Req(Req), .EPCOut(EPCOut), .EXL(EXL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_req();
        logic exl, ie;
        logic [5:0] im;
        exl = m_sr[1];
        ie  = m_sr[0];
        im  = m_sr[15:10];
        return (M_valid && ie && !exl && ((HWInt & im) != 0)) ||
               (M_valid && !exl && (M_ExcCode != 0));
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic bd,
                         input logic [4:0] code, input logic [5:0] hw, input logic eret,
                         input logic we, input logic [4:0] addr, input logic [31:0] din);
        M_valid = v; M_PC = pc; M_BD = bd; M_ExcCode = code; HWInt = hw;
        M_EXLClr = eret; cp0_we = we; cp0_addr = addr; cp0_din = din;
    endtask

    task automatic model_reset();
        m_sr = 0; m_cause = 0; m_epc = 0;
    endtask

    // One clock: check combinational outputs, take the edge, update the model,
    // check registered state, then return at the following falling edge.
    task automatic cycle(input string tag);
        logic        r;
        logic        is_int;
        logic [31:0] bdw, code;
        #1;
        r = m_req();
        chk({tag, "_req"}, {31'd0, Req}, {31'd0, r});
        chk({tag, "_rd"}, cp0_dout, m_read(cp0_addr));
        @(posedge clk);
        is_int = M_valid && m_sr[0] && !m_sr[1] && ((HWInt & m_sr[15:10]) != 0);
        if (r) begin
            m_sr  = m_sr | 32'h2;
            bdw   = M_BD ? 32'h8000_0000 : 32'h0;
            code  = is_int ? 32'd0 : {27'd0, M_ExcCode};
            m_cause = bdw | (code * 4);
            m_epc = (M_BD ? M_PC - 4 : M_PC) & ~32'd3;
        end else if (M_EXLClr) begin
            m_sr = m_sr & ~32'h2;
        end else if (cp0_we) begin
            if (cp0_addr == 5'd12) m_sr = cp0_din & 32'h0000_FC03;
            else if (cp0_addr == 5'd14) m_epc = cp0_din & ~32'd3;
        end
        m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} * 1024);
        #1;
        chk({tag, "_exl"}, {31'd0, EXL}, {31'd0, m_sr[1]});
        chk({tag, "_epc"}, EPCOut, m_epc);
        chk({tag, "_rd2"}, cp0_dout, m_read(cp0_addr));
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] codes [6];
        codes = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};

        reset = 1'b0;
        drive(1, 32'h3000, 0, 5'd10, 6'd0, 0, 0, 5'd12, 0);
        model_reset();
        #1;
        chk("rst_req", {31'd0, Req}, 32'd0);
        chk("rst_sr", cp0_dout, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Exception
        drive(1, 32'h3010, 0, 5'd10, 6'd0, 0, 0, 5'd13, 0);
        cycle("exc");
        chk("exc_epc_c", EPCOut, 32'h3010);
        chk("exc_cause_c", cp0_dout, 32'h0000_0028);
        chk("exc_exl_c", {31'd0, EXL}, 32'd1);

        drive(1, 32'h3014, 0, 5'd0, 6'd0, 1, 0, 5'd14, 0);
        cycle("eret1");
        chk("eret1_exl_c", {31'd0, EXL}, 32'd0);
        chk("eret1_epc_c", EPCOut, 32'h3010);

        // Delay-slot interrupt
        drive(1, 32'h3018, 0, 5'd0, 6'd0, 0, 1, 5'd12, 32'h0000_0401);
        cycle("mtc0_sr");
        drive(1, 32'h3024, 1, 5'd0, 6'b000001, 0, 0, 5'd13, 0);
        #1 chk("dsi_req_c", {31'd0, Req}, 32'd1);
        cycle("dsi");
        chk("dsi_epc_c", EPCOut, 32'h3020);
        chk("dsi_cause_c", cp0_dout, 32'h8000_0400);

        drive(1, 32'h3028, 0, 5'd0, 6'd0, 1, 0, 5'd12, 0);
        cycle("eret2");

        // Priority then masking
        drive(1, 32'h3030, 0, 5'd12, 6'b000001, 0, 0, 5'd13, 0);
        cycle("prio");
        chk("prio_code_c", cp0_dout & 32'h7C, 32'd0);
        drive(1, 32'h3034, 0, 5'd12, 6'd0, 0, 0, 5'd13, 0);
        #1 chk("mask_req_c", {31'd0, Req}, 32'd0);
        cycle("mask");

        // Collision: trap beats mtc0 EPC
        drive(1, 32'h3038, 0, 5'd0, 6'd0, 1, 0, 5'd14, 0);
        cycle("eret3");
        drive(1, 32'h303C, 0, 5'd8, 6'd0, 0, 1, 5'd14, 32'h5000);
        cycle("coll");
        chk("coll_epc_c", EPCOut, 32'h303C);
        drive(1, 32'h3040, 0, 5'd0, 6'd0, 1, 0, 5'd12, 0);
        cycle("eret4");

        // Bubble deferral
        for (int i = 0; i < 2; i++) begin
            drive(0, 32'h0, 0, 5'd0, 6'b000001, 0, 0, 5'd14, 0);
            #1 chk("bub_req_c", {31'd0, Req}, 32'd0);
            cycle("bub");
        end
        drive(1, 32'h3040, 0, 5'd0, 6'b000001, 0, 0, 5'd14, 0);
        cycle("bubv");
        chk("bubv_epc_c", EPCOut, 32'h3040);
        drive(1, 32'h3044, 0, 5'd0, 6'd0, 1, 0, 5'd14, 0);
        cycle("eret5");

        // Interrupt withdrawn before a valid slot
        drive(0, 32'h0, 0, 5'd0, 6'b000001, 0, 0, 5'd13, 0);
        cycle("wd0");
        drive(1, 32'h3048, 0, 5'd0, 6'd0, 0, 0, 5'd13, 0);
        #1 chk("wd_req_c", {31'd0, Req}, 32'd0);
        cycle("wd1");

        // Delay slot at the reset PC
        drive(1, 32'h3000, 1, 5'd4, 6'd0, 0, 0, 5'd14, 0);
        cycle("pc0");
        chk("pc0_epc_c", EPCOut, 32'h2FFC);

        // Reset mid-handler
        drive(1, 32'h3050, 0, 5'd10, 6'd0, 0, 0, 5'd12, 0);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("rmh_req", {31'd0, Req}, 32'd0);
        chk("rmh_exl", {31'd0, EXL}, 32'd0);
        chk("rmh_epc", EPCOut, 32'd0);
        for (int a = 12; a <= 14; a++) begin
            cp0_addr = 5'(a);
            #1 chk("rmh_rd", cp0_dout, 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [4:0]  a;
            logic [31:0] d;
            a = 5'(10 + $urandom_range(0, 5));
            d = $urandom;
            if ($urandom_range(0, 3) == 0) d = d | 32'h1;
            drive($urandom_range(0, 3) != 0,
                  32'h3000 + ($urandom_range(0, 255) * 4),
                  $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 2) == 0) ? codes[$urandom_range(0, 5)] : 5'd0,
                  ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  a, d);
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt controller (CP0 subset) for the 5-stage pipeline; evaluates in M stage.
- Merges the M-stage exception code with the six external interrupt lines.
- Drives the PC redirect request and keeps SR/Cause/EPC.
- Serves mfc0/mtc0 and supplies the eret return address to the fetch PC.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, handler entry; exported for the PC block.
- SR_ADDR, 12, CP0 register number of SR.
- CAUSE_ADDR, 13, CP0 register number of Cause.
- EPC_ADDR, 14, CP0 register number of EPC.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- M_valid  in  1  M stage holds a real instruction, not a bubble
- M_PC  in  32  PC of the M-stage instruction
- M_BD  in  1  M instruction sits in a delay slot
- M_ExcCode  in  5  accumulated exception code, 0 = none
- HWInt  in  6  external interrupt lines, level-sensitive
- M_EXLClr  in  1  eret in M stage
- cp0_we  in  1  mtc0 write enable
- cp0_addr  in  5  CP0 register number (rd field)
- cp0_din  in  32  mtc0 write data
- cp0_dout  out  32  mfc0 read data
- Req  out  1  redirect PC to HANDLER_ADDR at the next edge
- EPCOut  out  32  current EPC, used on eret
- EXL  out  1  in-handler flag

Behaviour:
Registers:
- SR: IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
- EPC: 32 bits, bits [1:0] are always 0.

Reset (reset=0, asynchronous):
- SR, Cause and EPC clear to 0.
- Req=0, EXL=0, EPCOut=0, cp0_dout=0.

Request, combinational within the cycle:
- int_req = M_valid & IE & ~EXL & |(HWInt & IM)
- exc_req = M_valid & ~EXL & (M_ExcCode != 0)
- Req = int_req | exc_req
- Interrupt has priority over an exception in the same cycle.

On a clock edge with Req=1:
- EXL <= 1.
- Cause.ExcCode <= int_req ? 0 : M_ExcCode.
- Cause.BD <= M_BD.
- EPC <= (M_BD ? M_PC-4 : M_PC) & ~3.
- Any mtc0 in the same cycle is dropped.
- Any M_EXLClr in the same cycle is ignored.

On a clock edge with Req=0:
- If M_EXLClr=1: EXL <= 0.
- Else if cp0_we=1: write the addressed register.
  - SR: only IM, EXL and IE are writable.
  - EPC: written as cp0_din & ~3.
  - Cause and unmapped addresses: the write has no effect.

Every edge:
- Cause.IP <= HWInt, unconditionally, including the Req edge.

Outputs:
- EPCOut = EPC register, stable and registered. PC redirect on eret is the PC block's responsibility.
- cp0_dout is a combinational read of the addressed register. Unmapped addresses read 0.

State machine, implicit via EXL:
- NORMAL (EXL=0) -> HANDLER on Req.
- HANDLER (EXL=1) -> NORMAL on M_EXLClr, or on an mtc0 clearing SR.EXL.
- In HANDLER, Req stays 0: no nesting, and exceptions are masked.

Boundaries:
- Bubble (M_valid=0) with a pending interrupt: Req is held off until the first valid instruction, then taken against that instruction's PC/BD.
- M_PC = 0x3000 with BD=1: EPC = 0x2FFC; no range check.
- Interrupt deasserted before a valid slot: no request is taken.
- Reset mid-handler: returns to NORMAL with EPC=0.

Decomposition:
- Shared package holds:
  - CP0 register numbers.
  - SR/Cause field bit positions.
  - HANDLER_ADDR and the 0x3000 reset PC.
  - ExcCode enumeration: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
- A single flat module. No sub-module is warranted; the register file and request logic are tightly coupled.

Test Plan:
- Reset: reset=0 mid-run -> SR, Cause, EPC read 0; Req=0 immediately, without waiting for an edge.
- Exception: M_valid=1, M_PC=0x3010, M_ExcCode=10, BD=0 -> Req=1 that cycle; next cycle Cause.ExcCode=10, EPC=0x3010, EXL=1.
- Delay-slot interrupt: mtc0 SR=0x0000_0401, HWInt=6'b000001, M_PC=0x3024, BD=1 -> Req=1; EPC=0x3020, Cause=0x8000_0400 (BD set, IP[10] set, ExcCode 0).
- Priority and masking: interrupt plus M_ExcCode=12 in the same cycle -> ExcCode=0. Then, with EXL=1, a second exception -> Req=0.
- eret and collision: M_EXLClr=1 -> EXL=0 next cycle, EPCOut unchanged. Req and mtc0 EPC=0x5000 in the same cycle -> EPC takes the exception PC, not 0x5000.
- Bubble deferral: HWInt pending with M_valid=0 for 2 cycles -> Req=0 throughout; M_valid=1 at PC 0x3040 -> Req=1, EPC=0x3040.
